// File: rtl/mul_rs_dispatch.sv
// Mul/div reservation station: buffers issued ops, wakes operands from the CDB, dispatches one ready op at a time.
// Optional OLDEST_FIRST_EN: dispatch the oldest eligible entry instead of the lowest-index one.
module mul_rs_dispatch #(
    parameter int RS_DEPTH = 3,
    parameter int TAG_W    = 4
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_func,
    input  logic [TAG_W-1:0] issue_rd,
    input  logic [2:0]       issue_rob,
    input  logic             issue_s1_rdy,
    input  logic             issue_s2_rdy,
    input  logic [TAG_W-1:0] issue_s1_tag,
    input  logic [TAG_W-1:0] issue_s2_tag,
    input  logic [7:0]       issue_s1_data,
    input  logic [7:0]       issue_s2_data,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [15:0]      cdb_data,
    input  logic             ex_done,
    output logic             ex_b,
    output logic [2:0]       rs_index,
    output logic [7:0]       rs1_data,
    output logic [7:0]       rs2_data,
    output logic [3:0]       func,
    output logic [2:0]       rob_ind,
    output logic [TAG_W-1:0] rd,
    output logic [3:0]       mulcount
);
    localparam logic [3:0] DEPTH_C = 4'(RS_DEPTH);

    logic [RS_DEPTH-1:0] busy_q, busy_d, s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [RS_DEPTH-1:0] eligible, wake1, wake2;
    logic [3:0]          func_q    [RS_DEPTH];
    logic [TAG_W-1:0]    rd_q      [RS_DEPTH];
    logic [2:0]          rob_q     [RS_DEPTH];
    logic [TAG_W-1:0]    s1_tag_q  [RS_DEPTH];
    logic [TAG_W-1:0]    s2_tag_q  [RS_DEPTH];
    logic [7:0]          s1_data_q [RS_DEPTH];
    logic [7:0]          s2_data_q [RS_DEPTH];
`ifdef OLDEST_FIRST_EN
    logic [2:0]          age_q     [RS_DEPTH];
    logic [2:0]          age_d     [RS_DEPTH];
    logic [2:0]          sel_age;
    logic                found;
`endif
    logic                unit_busy_q, unit_busy_d;
    logic [3:0]          mulcount_q, mulcount_d;
    logic                ex_b_q;
    logic [2:0]          rs_index_q, rob_ind_q;
    logic [7:0]          rs1_data_q, rs2_data_q;
    logic [3:0]          func_out_q;
    logic [TAG_W-1:0]    rd_out_q;

    logic [2:0]          sel_idx, free_idx;
    logic                alloc, dispatch;
    logic                new_s1_rdy, new_s2_rdy;
    logic [7:0]          new_s1_data, new_s2_data;
    logic [7:0]          sel_s1_data, sel_s2_data;
    logic [3:0]          sel_func;
    logic [2:0]          sel_rob;
    logic [TAG_W-1:0]    sel_rd;

    assign issue_ready = (mulcount_q < DEPTH_C);
    assign alloc       = issue_valid && issue_ready;

    // A not-ready operand can be satisfied by a broadcast in the very cycle it is issued.
    assign new_s1_rdy  = issue_s1_rdy || (cdb_valid && issue_s1_tag == cdb_tag);
    assign new_s2_rdy  = issue_s2_rdy || (cdb_valid && issue_s2_tag == cdb_tag);
    assign new_s1_data = issue_s1_rdy ? issue_s1_data : cdb_data[7:0];
    assign new_s2_data = issue_s2_rdy ? issue_s2_data : cdb_data[7:0];

    always_comb begin
        eligible = busy_q & s1_rdy_q & s2_rdy_q;
        free_idx = '0;
        sel_idx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake1[i] = cdb_valid && busy_q[i] && !s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag);
            wake2[i] = cdb_valid && busy_q[i] && !s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = 3'(i);
        end
`ifdef OLDEST_FIRST_EN
        found   = 1'b0;
        sel_age = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (eligible[i] && (!found || age_q[i] < sel_age)) begin
                found   = 1'b1;
                sel_age = age_q[i];
                sel_idx = 3'(i);
            end
        end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) sel_idx = 3'(i);
        end
`endif
        dispatch    = !unit_busy_q && (|eligible);
        sel_s1_data = '0;
        sel_s2_data = '0;
        sel_func    = '0;
        sel_rob     = '0;
        sel_rd      = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_s1_data = s1_data_q[i];
                sel_s2_data = s2_data_q[i];
                sel_func    = func_q[i];
                sel_rob     = rob_q[i];
                sel_rd      = rd_q[i];
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        s1_rdy_d = s1_rdy_q | wake1;
        s2_rdy_d = s2_rdy_q | wake2;
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef OLDEST_FIRST_EN
            age_d[i] = age_q[i];
            if (dispatch && busy_q[i] && age_q[i] > sel_age) age_d[i] = age_q[i] - 3'd1;
`endif
            if (dispatch && sel_idx == 3'(i)) busy_d[i] = 1'b0;
            if (alloc && free_idx == 3'(i)) begin
                busy_d[i]   = 1'b1;
                s1_rdy_d[i] = new_s1_rdy;
                s2_rdy_d[i] = new_s2_rdy;
`ifdef OLDEST_FIRST_EN
                age_d[i]    = dispatch ? mulcount_q[2:0] - 3'd1 : mulcount_q[2:0];
`endif
            end
        end
        unique case ({alloc, dispatch})
            2'b10:   mulcount_d = mulcount_q + 4'd1;
            2'b01:   mulcount_d = mulcount_q - 4'd1;
            default: mulcount_d = mulcount_q;
        endcase
        if (dispatch)     unit_busy_d = 1'b1;
        else if (ex_done) unit_busy_d = 1'b0;
        else              unit_busy_d = unit_busy_q;
    end

    // Control state and dispatch output registers
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            s1_rdy_q    <= '0;
            s2_rdy_q    <= '0;
            unit_busy_q <= 1'b0;
            mulcount_q  <= '0;
            ex_b_q      <= 1'b0;
            rs_index_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            func_out_q  <= '0;
            rob_ind_q   <= '0;
            rd_out_q    <= '0;
`ifdef OLDEST_FIRST_EN
            for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
`endif
        end else begin
            busy_q      <= busy_d;
            s1_rdy_q    <= s1_rdy_d;
            s2_rdy_q    <= s2_rdy_d;
            unit_busy_q <= unit_busy_d;
            mulcount_q  <= mulcount_d;
            ex_b_q      <= dispatch;
`ifdef OLDEST_FIRST_EN
            for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= age_d[i];
`endif
            if (dispatch) begin
                rs_index_q <= sel_idx;
                rs1_data_q <= sel_s1_data;
                rs2_data_q <= sel_s2_data;
                func_out_q <= sel_func;
                rob_ind_q  <= sel_rob;
                rd_out_q   <= sel_rd;
            end
        end
    end

    // Entry payload; validity is tracked by the busy/rdy bits above
    always_ff @(posedge clk1) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (alloc && free_idx == 3'(i)) begin
                func_q[i]    <= issue_func;
                rd_q[i]      <= issue_rd;
                rob_q[i]     <= issue_rob;
                s1_tag_q[i]  <= issue_s1_tag;
                s2_tag_q[i]  <= issue_s2_tag;
                s1_data_q[i] <= new_s1_data;
                s2_data_q[i] <= new_s2_data;
            end else begin
                if (wake1[i]) s1_data_q[i] <= cdb_data[7:0];
                if (wake2[i]) s2_data_q[i] <= cdb_data[7:0];
            end
        end
    end

    assign ex_b     = ex_b_q;
    assign rs_index = rs_index_q;
    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign func     = func_out_q;
    assign rob_ind  = rob_ind_q;
    assign rd       = rd_out_q;
    assign mulcount = mulcount_q;
endmodule
